prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Hardware boot loader for the multicycle MIPS.
- Receives a program image as a byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them to unified memory from byte address 0 upward.
- Holds the CPU in reset until the whole image has been written and its checksum verified.
- Sits between the host byte link (UART receiver or similar) and the write port of the shared memory. It is the writing end of the memory that the CPU reads as instructions.

Parameters:
- MAX_WORDS, 64, maximum image length in words; headers above this are rejected.
- ADDR_WIDTH, 32, width of Mem_Addr (byte address).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- byte_data  input  8  incoming image byte.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  synchronous restart request.
- Mem_WE  output  1  memory write enable, one-cycle pulse per word.
- Mem_Addr  output  ADDR_WIDTH  byte address of the write (4*word_index).
- Mem_WD  output  32  word to write.
- cpu_rst_n  output  1  active-low reset to the CPU; released only after a good load.
- done  output  1  image loaded and checksum OK (sticky).
- error  output  1  bad header or checksum mismatch (sticky).

Behaviour:
- Reset (rst=1, asynchronous):
  - State IDLE; counters and checksum cleared.
  - Outputs: byte_ready=0, Mem_WE=0, Mem_Addr=0, Mem_WD=0, cpu_rst_n=0, done=0, error=0.
- All outputs are registered. byte_ready is computed from the next state.
- byte_ready becomes 1 on the first rising edge after rst deasserts.
- A byte is accepted on a rising edge where byte_valid=1 and byte_ready=1. No other byte is consumed.
- Stream format:
  - 1 header byte N = word count.
  - Then 4*N payload bytes, most-significant byte first per word.
  - Then 1 checksum byte = XOR of all payload bytes (the header is excluded).
- State IDLE (byte_ready=1):
  - Header accepted with 1 <= N <= MAX_WORDS: latch N; word_index=0; byte_cnt=0; chk=0; go to LOAD.
  - Header N=0 or N>MAX_WORDS: go to ERR.
- State LOAD (byte_ready=1):
  - Each accepted byte shifts into the word assembler and is XORed into chk; byte_cnt increments mod 4.
  - On acceptance of the 4th byte of a word, at edge k:
    - Mem_WD = assembled word and Mem_Addr = 4*word_index during cycle k+1.
    - Mem_WE=1 for exactly that one cycle.
    - word_index increments.
  - Mem_WE=0 at all other times. Mem_Addr and Mem_WD hold their last values.
  - After the write of word N-1 is scheduled, go to CHECK.
  - Bytes may arrive back-to-back, including during a write cycle. No backpressure in LOAD.
- State CHECK (byte_ready=1):
  - Checksum byte accepted and equal to chk: go to DONE.
  - Mismatch: go to ERR.
- State DONE:
  - byte_ready=0, done=1, cpu_rst_n=1, all from the same edge that enters DONE.
  - Stays in DONE until rst or reload.
- State ERR:
  - byte_ready=0, error=1, cpu_rst_n=0.
  - Stays in ERR until rst or reload.
- reload=1 at a rising edge, from any state, including mid-word or mid-image:
  - Go to IDLE and clear counters, chk and the partial word.
  - done=0, error=0, cpu_rst_n=0, Mem_WE=0 on that edge.
  - Any byte presented on that edge is ignored. byte_ready=1 from the next cycle.
  - Words already written are not erased.
- reload and a byte acceptance on the same edge: reload wins.
- rst always overrides reload.
- Maximum image: N=MAX_WORDS, so the last write goes to Mem_Addr=4*(MAX_WORDS-1). word_index never wraps.
- cpu_rst_n never glitches high before DONE.

Test Plan:
1. After reset, send 01, 20,08,00,05, 2D -> one Mem_WE pulse with Mem_Addr=0x0, Mem_WD=0x20080005, one cycle after byte 05 is accepted; then done=1, cpu_rst_n=1, byte_ready=0.
2. Send N=3 with words 0x11111111, 0x22222222, 0x33333333, back-to-back bytes, checksum 00 -> writes to addresses 0x0, 0x4, 0x8 in order, each Mem_WE exactly one cycle; then done=1.
3. Same as scenario 1 but checksum byte 2C -> error=1, done=0, cpu_rst_n stays 0, byte_ready=0.
4. Header 00, then separately header 0x41 with MAX_WORDS=64 -> error=1 immediately after the header byte in each case, with no Mem_WE.
5. Send 02 and 6 payload bytes, pulse reload, then a full valid N=1 image -> the first image produces exactly 1 write; after reload, state is IDLE, and the new image writes to Mem_Addr=0 and ends with done=1.
6. Toggle byte_valid randomly and assert rst mid-LOAD -> only handshaked bytes are counted; rst clears all outputs asynchronously and a fresh load then completes correctly.

Source files
------------

// File: rtl/prog_loader.sv
// Boot loader: byte stream (N, 4*N payload bytes MSB-first, XOR checksum) -> word writes at byte address 0 upward.
// Each word is written one cycle after its 4th byte is accepted; no backpressure while loading, and input is refused in DONE/ERR.
module prog_loader #(
    parameter int MAX_WORDS  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  reload,
    output logic                  Mem_WE,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [31:0]           Mem_WD,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    localparam int         IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        n_q;
    logic [IDX_W-1:0]        widx_q;
    logic [1:0]              byte_cnt_q;
    logic [7:0]              chk_q;
    logic [23:0]             asm_q;
    logic                    byte_ready_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [31:0]             mem_wd_q;
    logic                    cpu_rst_n_q;
    logic                    done_q;
    logic                    error_q;

    logic        accept;
    logic        last_word;
    logic [31:0] word_full;

    assign accept    = byte_valid & byte_ready_q;
    assign last_word = (widx_q == n_q - 1'b1);
    assign word_full = {asm_q, byte_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            widx_q       <= '0;
            byte_cnt_q   <= '0;
            chk_q        <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else if (reload) begin
            // Previously written words stay in memory; only loader state restarts.
            state_q      <= S_IDLE;
            n_q          <= '0;
            widx_q       <= '0;
            byte_cnt_q   <= '0;
            chk_q        <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b1;
            mem_we_q     <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    byte_ready_q <= 1'b1;
                    if (accept) begin
                        if (byte_data != 8'd0 && byte_data <= MAX_N) begin
                            state_q    <= S_LOAD;
                            n_q        <= IDX_W'(byte_data);
                            widx_q     <= '0;
                            byte_cnt_q <= '0;
                            chk_q      <= '0;
                            asm_q      <= '0;
                        end else begin
                            state_q      <= S_ERR;
                            byte_ready_q <= 1'b0;
                            error_q      <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    byte_ready_q <= 1'b1;
                    if (accept) begin
                        chk_q      <= chk_q ^ byte_data;
                        asm_q      <= {asm_q[15:0], byte_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_q   <= 1'b1;
                            mem_wd_q   <= word_full;
                            mem_addr_q <= ADDR_WIDTH'(widx_q) << 2;
                            widx_q     <= widx_q + 1'b1;
                            if (last_word) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    byte_ready_q <= 1'b1;
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        if (byte_data == chk_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    byte_ready_q <= 1'b0;
                end
                S_ERR: begin
                    byte_ready_q <= 1'b0;
                    cpu_rst_n_q  <= 1'b0;
                end
                default: begin
                    state_q      <= S_ERR;
                    byte_ready_q <= 1'b0;
                    error_q      <= 1'b1;
                    cpu_rst_n_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign Mem_WE     = mem_we_q;
    assign Mem_Addr   = mem_addr_q;
    assign Mem_WD     = mem_wd_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte images in, memory writes and status flags checked against hand-computed values.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        reload = 1'b0;
    logic        Mem_WE;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WD;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int glitches = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    prog_loader #(.MAX_WORDS(64), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .reload     (reload),
        .Mem_WE     (Mem_WE),
        .Mem_Addr   (Mem_Addr),
        .Mem_WD     (Mem_WD),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // One negedge sample per cycle, so a WE held high for two cycles shows up as two writes.
    always @(negedge clk) begin
        if (Mem_WE === 1'b1) begin
            wr_addr.push_back(Mem_Addr);
            wr_data.push_back(Mem_WD);
        end
        if (cpu_rst_n === 1'b1 && done !== 1'b1) glitches++;
    end

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: byte_ready=%b after %0d cycles, required 1", byte_ready, t);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_reload(input logic hold_byte);
        reload     = 1'b1;
        byte_valid = hold_byte;
        byte_data  = 8'h00;
        @(posedge clk); #1;
        reload     = 1'b0;
        byte_valid = 1'b0;
        checks++;
        if ({byte_ready, done, error, cpu_rst_n, Mem_WE} !== 5'b10000) begin
            errors++;
            $display("FAIL reload_state: ready,done,error,cpu_rst_n,we=%b required 10000",
                     {byte_ready, done, error, cpu_rst_n, Mem_WE});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({byte_ready, Mem_WE, done, error, cpu_rst_n} !== 5'b0 || Mem_Addr !== 32'h0 || Mem_WD !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready,we,done,err,crn=%b addr=%h wd=%h required all 0",
                     {byte_ready, Mem_WE, done, error, cpu_rst_n}, Mem_Addr, Mem_WD);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: byte_ready=%b required 1", byte_ready);
        end
    endtask

    task automatic test_single_word();
        clear_writes();
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        checks++;
        if (Mem_WE !== 1'b1 || Mem_Addr !== 32'h0 || Mem_WD !== 32'h20080005) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%h wd=%h required 1/00000000/20080005", Mem_WE, Mem_Addr, Mem_WD);
        end
        send_byte(8'h2D, 0);
        checks++;
        if ({done, cpu_rst_n, byte_ready, error, Mem_WE} !== 5'b11000) begin
            errors++;
            $display("FAIL single_done: done,crn,ready,err,we=%b required 11000",
                     {done, cpu_rst_n, byte_ready, error, Mem_WE});
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (wr_addr.size() != 1) begin
            errors++;
            $display("FAIL single_write_count: %0d writes, required 1", wr_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[3];
        exp_w[0] = 32'h11111111;
        exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333;
        do_reload(1'b0);
        clear_writes();
        send_byte(8'h03, 0);
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++)
                send_byte(exp_w[w][31-8*k -: 8], 0);
        send_byte(8'h00, 0);
        checks++;
        if (wr_addr.size() != 3) begin
            errors++;
            $display("FAIL b2b_write_count: %0d writes, required 3", wr_addr.size());
        end else begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (wr_addr[w] !== 32'(4 * w) || wr_data[w] !== exp_w[w]) begin
                    errors++;
                    $display("FAIL b2b_write%0d: addr=%h wd=%h required %h/%h", w, wr_addr[w], wr_data[w], 4 * w, exp_w[w]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b error=%b required 1/0", done, error);
        end
    endtask

    task automatic test_bad_checksum();
        do_reload(1'b0);
        clear_writes();
        send_byte(8'h01, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h2C, 0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({error, done, cpu_rst_n, byte_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL bad_checksum: err,done,crn,ready=%b required 1000", {error, done, cpu_rst_n, byte_ready});
        end
    endtask

    task automatic test_bad_header();
        do_reload(1'b0);
        clear_writes();
        send_byte(8'h00, 0);
        checks++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL header_zero: err=%b ready=%b done=%b required 1/0/0", error, byte_ready, done);
        end
        do_reload(1'b0);
        send_byte(8'h41, 0);
        checks++;
        if (error !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL header_over: err=%b ready=%b required 1/0", error, byte_ready);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL header_writes: %0d writes, required 0", wr_addr.size());
        end
    endtask

    task automatic test_max_image();
        logic [7:0]  chk;
        logic [31:0] w;
        do_reload(1'b0);
        clear_writes();
        chk = 8'h00;
        send_byte(8'h40, 0);
        checks++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL header_max: err=%b ready=%b required 0/1", error, byte_ready);
        end
        for (int i = 0; i < 64; i++) begin
            w = {8'(i), 8'(i + 1), 8'(3 * i), 8'hA5};
            for (int k = 0; k < 4; k++) begin
                chk = chk ^ w[31-8*k -: 8];
                send_byte(w[31-8*k -: 8], 0);
            end
        end
        send_byte(chk, 0);
        checks++;
        if (wr_addr.size() != 64) begin
            errors++;
            $display("FAIL max_write_count: %0d writes, required 64", wr_addr.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                w = {8'(i), 8'(i + 1), 8'(3 * i), 8'hA5};
                checks++;
                if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== w) begin
                    errors++;
                    $display("FAIL max_write%0d: addr=%h wd=%h required %h/%h", i, wr_addr[i], wr_data[i], 4 * i, w);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL max_done: done=%b error=%b required 1/0", done, error);
        end
    endtask

    task automatic test_reload_mid_image();
        do_reload(1'b0);
        clear_writes();
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (wr_addr.size() != 1 || wr_data[0] !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL partial_writes: %0d writes, required 1 of AABBCCDD", wr_addr.size());
        end
        // A header 00 offered on the reload edge must be dropped, else the loader would land in ERR.
        do_reload(1'b1);
        clear_writes();
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        send_byte(8'h22, 0);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reload_image_write: %0d writes, required 1 to 00000000 of DEADBEEF", wr_addr.size());
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reload_image_done: done=%b err=%b crn=%b required 1/0/1", done, error, cpu_rst_n);
        end
    endtask

    task automatic test_random_valid_and_reset();
        do_reload(1'b0);
        clear_writes();
        send_byte(8'h02, 3);
        send_byte(8'h55, 3);
        send_byte(8'h66, 3);
        send_byte(8'h77, 3);
        send_byte(8'h88, 3);
        checks++;
        if (Mem_WE !== 1'b1 || Mem_WD !== 32'h55667788 || Mem_Addr !== 32'h0) begin
            errors++;
            $display("FAIL gapped_write: we=%b addr=%h wd=%h required 1/00000000/55667788", Mem_WE, Mem_Addr, Mem_WD);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, Mem_WE, done, error, cpu_rst_n} !== 5'b0 || Mem_Addr !== 32'h0 || Mem_WD !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ready,we,done,err,crn=%b addr=%h wd=%h required all 0",
                     {byte_ready, Mem_WE, done, error, cpu_rst_n}, Mem_Addr, Mem_WD);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_writes();
        send_byte(8'h02, 3);
        send_byte(8'h01, 3);
        send_byte(8'h02, 3);
        send_byte(8'h03, 3);
        send_byte(8'h04, 3);
        send_byte(8'hA0, 3);
        send_byte(8'hB0, 3);
        send_byte(8'hC0, 3);
        send_byte(8'hD0, 3);
        send_byte(8'h04, 3);
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL fresh_write_count: %0d writes, required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h01020304 ||
                wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hA0B0C0D0) begin
                errors++;
                $display("FAIL fresh_writes: %h/%h %h/%h required 00000000/01020304 00000004/A0B0C0D0",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL fresh_done: done=%b error=%b required 1/0", done, error);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bad_checksum();
        test_bad_header();
        test_max_image();
        test_reload_mid_image();
        test_random_valid_and_reset();
        checks++;
        if (glitches != 0) begin
            errors++;
            $display("FAIL cpu_rst_glitch: %0d cycles with cpu_rst_n=1 and done=0, required 0", glitches);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
